logic_alu_pipe: RTL and testbench

LOGIC_ALU_PIPE -- requirements
Module: logic_alu_pipe

---
 rtl/alu_pkg.sv | 14 +
 rtl/logic_select.sv | 32 +++
 rtl/logic_alu_pipe.sv | 84 ++++++++
 tb/tb_logic_alu_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the logic ALU pipeline: default datapath width and
// the function-select encodings.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } alu_op_e;

endpackage

// File: rtl/logic_select.sv
// Combinational four-function bitwise unit: computes AND/OR/XOR/NOR of the
// operands and selects one by op.
module logic_select
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;

    assign w_and = a & b;
    assign w_or  = a | b;
    assign w_xor = a ^ b;

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND: result = w_and;
            OP_OR:  result = w_or;
            OP_XOR: result = w_xor;
            OP_NOR: result = ~w_or;
        endcase
    end

endmodule

// File: rtl/logic_alu_pipe.sv
// Two-stage valid/ready logic ALU: s1 captures operands, s2 holds the
// registered result and zero flag that drive the outputs directly.
module logic_alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    alu_op_e          r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_y;
    logic             r_s2_zero;

    logic             w_s2_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;

    // s2 may take new contents whenever it is empty or being drained this cycle.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && in_ready;

    logic_select #(
        .WIDTH (WIDTH)
    ) u_logic_select (
        .a      (r_s1_a),
        .b      (r_s1_b),
        .op     (r_s1_op),
        .result (w_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_AND;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_op    <= alu_op_e'(op);
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_zero  <= 1'b1;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y    <= w_result;
                r_s2_zero <= (w_result == '0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign y         = r_s2_y;
    assign zero      = r_s2_zero;

endmodule

// File: tb/tb_logic_alu_pipe.sv
// Self-checking bench for logic_alu_pipe: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_logic_alu_pipe;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_acc = 0;

    logic [W-1:0] exp_q[$];
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_y     = '0;
    int unsigned  idle_run   = 0;

    logic_alu_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [1:0] mop);
        case (mop)
            2'd0:    return ma & mb;
            2'd1:    return ma | mb;
            2'd2:    return ma ^ mb;
            default: return ~(ma | mb);
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight results in acceptance order, capacity two.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
            idle_run   = 0;
        end else begin
            chk("in_ready", W'(in_ready), W'((exp_q.size() < 2) || out_ready));
            if (prev_stall) begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_y", y, prev_y);
            end
            if (exp_q.size() > 0 && !out_valid) idle_run++;
            else idle_run = 0;
            if (idle_run > 1) chk("latency", W'(idle_run), W'(1));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", W'(out_valid), W'(0));
                end else begin
                    chk("y", y, exp_q[0]);
                    chk("zero", W'(zero), W'(exp_q[0] == '0));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, op));
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_offer(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = top;
    endtask

    task automatic drain();
        int unsigned n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        bit           acc;
        int unsigned  k;
        int unsigned  cyc;
        logic [W-1:0] y_hold;
        logic [1:0]   ops[3];

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = 2'd0;

        #3;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_y", y, 32'h0);
        chk("rst_zero", W'(zero), W'(1));
        tick();
        #2;
        reset = 1'b0;

        // Accept in the first cycle after release; result two edges later.
        set_op(32'hF0F0F0F0, 32'h0FF00FF0, 2'b00);
        #1;
        chk("first_in_ready", W'(in_ready), W'(1));
        tick();
        in_valid = 1'b0;
        chk("lat1_out_valid", W'(out_valid), W'(0));
        tick();
        chk("and_valid", W'(out_valid), W'(1));
        chk("and_y", y, 32'h00F000F0);
        chk("and_zero", W'(zero), W'(0));

        // Back-to-back OR, XOR, NOR.
        set_op(32'hFFFF0000, 32'h00FFFF00, 2'b01);
        tick();
        set_op(32'hFFFF0000, 32'h00FFFF00, 2'b10);
        tick();
        chk("b2b_or", y, 32'hFFFFFF00);
        set_op(32'hFFFF0000, 32'h00FFFF00, 2'b11);
        tick();
        chk("b2b_xor", y, 32'hFF00FF00);
        in_valid = 1'b0;
        tick();
        chk("b2b_nor", y, 32'h000000FF);
        chk("b2b_valid", W'(out_valid), W'(1));

        set_op(32'hFFFFFFFF, 32'h0, 2'b11);
        tick();
        in_valid = 1'b0;
        tick();
        chk("nor_zero_y", y, 32'h0);
        chk("nor_zero_flag", W'(zero), W'(1));
        drain();

        // Stall: three ops offered with out_ready low for five cycles.
        out_ready = 1'b0;
        ops[0] = 2'b00;
        ops[1] = 2'b01;
        ops[2] = 2'b10;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            set_op(32'h12345678 + k, 32'h0F0F0F0F, ops[k]);
            step_offer(acc);
            if (acc) k++;
        end
        chk("stall_accepted", W'(k), W'(2));
        chk("stall_in_ready", W'(in_ready), W'(0));
        chk("stall_hold_y", y, model(32'h12345678, 32'h0F0F0F0F, 2'b00));
        y_hold = y;
        tick();
        chk("stall_hold_y2", y, y_hold);
        out_ready = 1'b1;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 10) begin
            step_offer(acc);
            cyc++;
        end
        chk("stall_third_accept", W'(acc), W'(1));
        drain();

        // Random valid/ready traffic.
        k   = 0;
        cyc = 0;
        while (k < 1000 && cyc < 20000) begin
            in_valid  = ($urandom % 4) != 0;
            a         = $urandom;
            b         = ($urandom % 8 == 0) ? a : $urandom;
            op        = 2'($urandom % 4);
            out_ready = ($urandom % 3) != 0;
            step_offer(acc);
            if (acc) k++;
            cyc++;
        end
        chk("random_ops_done", W'(k), W'(1000));
        drain();

        // Asynchronous reset with two ops in flight.
        out_ready = 1'b0;
        set_op(32'hAAAA5555, 32'h0000FFFF, 2'b01);
        step_offer(acc);
        set_op(32'h13579BDF, 32'h2468ACE0, 2'b10);
        step_offer(acc);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_y", y, 32'h0);
        chk("arst_zero", W'(zero), W'(1));
        chk("arst_in_ready", W'(in_ready), W'(1));
        tick();
        tick();
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_stale", W'(out_valid), W'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
